serial_multiplier_core: RTL and testbench

Sequential shift-and-add multiplier core that sits directly downstream of the right-shifting parallel-load shift register. It drives that register's `load` and `shift` controls and consumes its `serialOutput` one multiplier bit per cycle, LSB first. It accumulates the product of that multiplier and a locally held multiplicand. It reports completion with a one-cycle `done` pulse and holds the `2*WORD_LENGTH`-bit product until the next operation.

---
 rtl/serial_mult_pkg.sv | 16 +
 rtl/mult_bit_counter.sv | 39 +++
 rtl/serial_multiplier_core.sv | 130 +++++++++++++
 tb/tb_serial_multiplier_core.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_mult_pkg.sv
// Shared types and helpers for the serial shift-and-add multiplier core.
package serial_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bit-position counter width; never narrower than one bit.
  function automatic int cnt_width(input int word_length);
    return (word_length <= 2) ? 1 : $clog2(word_length);
  endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// Multiplier bit-position counter: synchronous clear, enable, terminal flag at WORD_LENGTH-1.
module mult_bit_counter
  import serial_mult_pkg::*;
#(
  parameter  int WORD_LENGTH = 8,
  localparam int CW          = cnt_width(WORD_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == CW'(WORD_LENGTH - 1));

endmodule

// File: rtl/serial_multiplier_core.sv
// Shift-and-add multiplier consuming one multiplier bit per cycle, LSB first, from an upstream shift register.
// Define SERIAL_MULT_SIGNED_EN for two's-complement operands; unsigned otherwise.
module serial_multiplier_core
  import serial_mult_pkg::*;
#(
  parameter int WORD_LENGTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WORD_LENGTH-1:0]   multiplicand,
  input  logic                     serialInput,
  output logic                     load,
  output logic                     shift,
  output logic                     busy,
  output logic                     done,
  output logic [2*WORD_LENGTH-1:0] product
);

  localparam int PW = 2 * WORD_LENGTH;
  localparam int CW = cnt_width(WORD_LENGTH);

  state_t                 state_q, state_d;
  logic                   load_q, load_d;
  logic                   shift_q, shift_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [WORD_LENGTH-1:0] mcand_q, mcand_d;
  logic [PW-1:0]          acc_q, acc_d;

  logic [CW-1:0] bit_count;
  logic          bit_last;
  logic [PW-1:0] mcand_ext;
  logic [PW-1:0] partial;

  mult_bit_counter #(
    .WORD_LENGTH(WORD_LENGTH)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_q == LOAD),
    .enable   (state_q == RUN),
    .count    (bit_count),
    .terminal (bit_last)
  );

`ifdef SERIAL_MULT_SIGNED_EN
  assign mcand_ext = {{WORD_LENGTH{mcand_q[WORD_LENGTH-1]}}, mcand_q};
`else
  assign mcand_ext = {{WORD_LENGTH{1'b0}}, mcand_q};
`endif

  assign partial = mcand_ext << bit_count;

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    shift_d = shift_q;
    busy_d  = busy_q;
    done_d  = done_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          mcand_d = multiplicand;
          load_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        state_d = RUN;
        load_d  = 1'b0;
        shift_d = 1'b1;
        acc_d   = '0;
      end
      RUN: begin
        if (serialInput) begin
`ifdef SERIAL_MULT_SIGNED_EN
          // The multiplier's sign bit carries negative weight.
          acc_d = bit_last ? (acc_q - partial) : (acc_q + partial);
`else
          acc_d = acc_q + partial;
`endif
        end
        if (bit_last) begin
          state_d = DONE;
          shift_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
    end
  end

  assign load    = load_q;
  assign shift   = shift_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: tb/tb_serial_multiplier_core.sv
// Self-checking bench for serial_multiplier_core (WORD_LENGTH=8) with an upstream shift register in the environment.
module tb_serial_multiplier_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  parallel_input = '0;
  logic        serial_input;
  logic        load, shift, busy, done;
  logic [15:0] product;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  serial_multiplier_core #(.WORD_LENGTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .serialInput  (serial_input),
    .load         (load),
    .shift        (shift),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  // Upstream right-shifting parallel-load register
  logic [7:0] sr_q;
  always @(posedge clk) begin
    if (reset)      sr_q <= '0;
    else if (load)  sr_q <= parallel_input;
    else if (shift) sr_q <= {1'b0, sr_q[7:1]};
  end
  assign serial_input = sr_q[0];

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
`ifdef SERIAL_MULT_SIGNED_EN
    sa = a[7] ? int'(a) - 256 : int'(a);
    sb = b[7] ? int'(b) - 256 : int'(b);
`else
    sa = int'(a);
    sb = int'(b);
`endif
    return 16'(sa * sb);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural timeline: age = cycles since the accepting start edge (0 = idle).
  int          age = 0;
  logic [7:0]  mc_m = '0, mp_m = '0;
  logic [15:0] held = '0;

  always @(posedge clk) begin
    if (reset) begin
      age  = 0;
      held = '0;
    end else if (age == 0) begin
      if (start) begin
        mc_m = multiplicand;
        age  = 1;
      end
    end else if (age == 1) begin
      mp_m = parallel_input;
      age  = 2;
    end else if (age < 10) begin
      age = age + 1;
      if (age == 10) held = ref_mul(mc_m, mp_m);
    end else begin
      age = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("load",  32'(load),  32'(age == 1));
      check("shift", 32'(shift), 32'(age >= 2 && age <= 9));
      check("busy",  32'(busy),  32'(age >= 1 && age <= 9));
      check("done",  32'(done),  32'(age == 10));
      if (age == 0 || age == 10) check("product", 32'(product), 32'(held));
    end
  end

  task automatic run_op(input logic [7:0] mc, input logic [7:0] mp, input logic [15:0] lit, input string tag);
    int lc, sc, bc;
    bit seen;
    @(negedge clk);
    multiplicand = mc; parallel_input = mp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lc = 0; sc = 0; bc = 0; seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      lc += int'(load); sc += int'(shift); bc += int'(busy);
      if (done) begin
        seen = 1;
        check({tag, "_latency"}, 32'(i), 32'd10);
        check({tag, "_product"}, 32'(product), 32'(lit));
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
    check({tag, "_load_cycles"},  32'(lc), 32'd1);
    check({tag, "_shift_cycles"}, 32'(sc), 32'd8);
    check({tag, "_busy_cycles"},  32'(bc), 32'd9);
    $display("op %s: %0d * %0d -> product=%h", tag, mc, mp, product);
  endtask

  initial begin
    int dc;
    logic [7:0] a, b;
    repeat (3) @(negedge clk);
    check("reset_product", 32'(product), 32'd0);
    check("reset_busy",    32'({load, shift, busy, done}), 32'd0);
    reset = 1'b0;
    chk_en = 1;

    run_op(8'd13, 8'd11, 16'h008F, "13x11");
`ifdef SERIAL_MULT_SIGNED_EN
    run_op(8'd255, 8'd255, 16'h0001, "255x255");
`else
    run_op(8'd255, 8'd255, 16'hFE01, "255x255");
`endif
    run_op(8'd200, 8'd0, 16'h0000, "200x0");
`ifdef SERIAL_MULT_SIGNED_EN
    run_op(8'hFD, 8'd5, 16'hFFF1, "FDx5");
`else
    run_op(8'hFD, 8'd5, 16'h04F1, "FDx5");
`endif

    // Second start during RUN cycle 3 must be ignored
    @(negedge clk);
    multiplicand = 8'd13; parallel_input = 8'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    multiplicand = 8'd99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dc = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dc++;
        check("ignored_start_product", 32'(product), 32'h008F);
      end
      @(negedge clk);
    end
    check("ignored_start_done_pulses", 32'(dc), 32'd1);
    $display("op ignored_start: done pulses=%0d product=%h", dc, product);

    // Reset during RUN cycle 4 abandons the operation
    multiplicand = 8'd255; parallel_input = 8'd255; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy",    32'(busy), 32'd0);
    check("midreset_product", 32'(product), 32'd0);
    dc = 0;
    for (int i = 0; i < 15; i++) begin
      dc += int'(done);
      @(negedge clk);
    end
    check("midreset_no_done", 32'(dc), 32'd0);
    $display("op midreset: busy=%0b product=%h done pulses=%0d", busy, product, dc);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      if (n < 4) b = (n[0]) ? 8'h80 : 8'hFF;
      run_op(a, b, ref_mul(a, b), "random");
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
